// File: rtl/rob_commit_unit_pkg.sv
// Shared constants, opcode classes and entry layout for the reorder buffer.
// Tag 0 is the "no tag" value and is never allocated.
package rob_commit_unit_pkg;

    localparam int ROB_SIZE            = 16;
    localparam int ROB_TAG_WIDTH       = 4;
    localparam int INSIDE_OPCODE_WIDTH = 6;

    localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;

    typedef logic [INSIDE_OPCODE_WIDTH-1:0] op_t;

    localparam op_t OP_NOP  = 6'd0;
    localparam op_t OP_ADD  = 6'd1;
    localparam op_t OP_SUB  = 6'd2;
    localparam op_t OP_JAL  = 6'd20;
    localparam op_t OP_JALR = 6'd21;
    localparam op_t OP_BEQ  = 6'd22;
    localparam op_t OP_BNE  = 6'd23;
    localparam op_t OP_BLT  = 6'd24;
    localparam op_t OP_BGE  = 6'd25;
    localparam op_t OP_BLTU = 6'd26;
    localparam op_t OP_BGEU = 6'd27;
    localparam op_t OP_LB   = 6'd28;
    localparam op_t OP_LH   = 6'd29;
    localparam op_t OP_LW   = 6'd30;
    localparam op_t OP_LBU  = 6'd31;
    localparam op_t OP_LHU  = 6'd32;
    localparam op_t OP_SB   = 6'd33;
    localparam op_t OP_SH   = 6'd34;
    localparam op_t OP_SW   = 6'd35;

    // Conditional branches only; jal/jalr are classified separately.
    function automatic logic is_branch_op(input op_t op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    function automatic logic is_jal_op(input op_t op);
        return op == OP_JAL;
    endfunction

    function automatic logic is_jalr_op(input op_t op);
        return op == OP_JALR;
    endfunction

    function automatic logic is_store_op(input op_t op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    typedef struct packed {
        op_t         op;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred;
        logic        ready;
        logic [31:0] value;
        logic        taken;
        logic [31:0] target;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_unit_ptr_ring.sv
// Head/tail/count bookkeeping for a ring whose slots run 1..N-1.
// Slot 0 is skipped so that tag 0 can mean "no tag".
module rob_ptr_ring
    import rob_commit_unit_pkg::*;
#(
    parameter int N = ROB_SIZE,
    parameter int W = ROB_TAG_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [W-1:0] tail,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(N + 1);

    logic [W-1:0]  head_q, head_d;
    logic [W-1:0]  tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [W-1:0] next_ptr(input logic [W-1:0] p);
        return (p == W'(N - 1)) ? W'(1) : p + W'(1);
    endfunction

    // Advance pointers and count; a flush restarts the ring at slot 1.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = W'(1);
            tail_d  = W'(1);
            count_d = '0;
        end else begin
            if (push) tail_d = next_ptr(tail_q);
            if (pop)  head_d = next_ptr(head_q);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Pointer registers; frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= W'(1);
            tail_q  <= W'(1);
            count_q <= '0;
        end else if (rdy) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign tail  = tail_q;
    assign full  = (count_q == CW'(N - 1));
    assign empty = (count_q == '0);

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates tags, captures CDB results, commits in order
// and raises a one-cycle flush on a mispredicted branch or jalr.
module rob_commit_unit #(
    parameter int ROB_SIZE = rob_commit_unit_pkg::ROB_SIZE,
    parameter int TAG_W    = rob_commit_unit_pkg::ROB_TAG_WIDTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          rdy,
    input  logic                                          in_fetcher_ce,
    input  logic [rob_commit_unit_pkg::INSIDE_OPCODE_WIDTH-1:0] in_decode_op,
    input  logic [4:0]                                    in_decode_rd,
    input  logic [31:0]                                   in_decode_pc,
    input  logic                                          in_decode_pred_taken,
    output logic [TAG_W-1:0]                              out_decode_rob_tag,
    output logic                                          out_fetcher_isidle,
    input  logic [TAG_W-1:0]                              in_decode_query_tag1,
    input  logic [TAG_W-1:0]                              in_decode_query_tag2,
    output logic                                          out_decode_query_ready1,
    output logic                                          out_decode_query_ready2,
    output logic [31:0]                                   out_decode_query_value1,
    output logic [31:0]                                   out_decode_query_value2,
    input  logic [TAG_W-1:0]                              in_alu_cdb_tag,
    input  logic [31:0]                                   in_alu_cdb_value,
    input  logic                                          in_alu_cdb_taken,
    input  logic [31:0]                                   in_alu_cdb_target,
    input  logic [TAG_W-1:0]                              in_slb_cdb_tag,
    input  logic [31:0]                                   in_slb_cdb_value,
    output logic [TAG_W-1:0]                              out_rob_cdb_tag,
    output logic [31:0]                                   out_rob_cdb_value,
    output logic [4:0]                                    out_reg_rd,
    output logic [31:0]                                   out_reg_value,
    output logic [TAG_W-1:0]                              out_reg_tag,
    output logic [TAG_W-1:0]                              out_slb_commit_tag,
    output logic                                          out_misbranch,
    output logic [31:0]                                   out_fetcher_newpc
);

    import rob_commit_unit_pkg::*;

    logic [TAG_W-1:0] head, tail;
    logic             full, empty;
    logic             alloc, commit;
    rob_entry_t       head_e;
    logic [31:0]      link, cvalue;

    rob_entry_t  entry_q [ROB_SIZE];
    rob_entry_t  entry_d [ROB_SIZE];

    logic [TAG_W-1:0] rob_cdb_tag_q, rob_cdb_tag_d;
    logic [31:0]      rob_cdb_value_q, rob_cdb_value_d;
    logic [4:0]       reg_rd_q, reg_rd_d;
    logic [31:0]      reg_value_q, reg_value_d;
    logic [TAG_W-1:0] reg_tag_q, reg_tag_d;
    logic [TAG_W-1:0] slb_commit_tag_q, slb_commit_tag_d;
    logic             misbranch_q, misbranch_d;
    logic [31:0]      newpc_q, newpc_d;

    rob_ptr_ring #(.N(ROB_SIZE), .W(TAG_W)) u_ring (
        .clk  (clk),
        .rst  (rst),
        .rdy  (rdy),
        .flush(misbranch_q),
        .push (alloc),
        .pop  (commit),
        .head (head),
        .tail (tail),
        .full (full),
        .empty(empty)
    );

    // Ready/value lookup with same-cycle forwarding from either CDB.
    function automatic logic [32:0] lookup(
        input logic [TAG_W-1:0] t,
        input logic             r,
        input logic [31:0]      v,
        input logic [TAG_W-1:0] at,
        input logic [31:0]      av,
        input logic [TAG_W-1:0] st,
        input logic [31:0]      sv
    );
        if (t == '0)      return {1'b0, 32'd0};
        else if (t == at) return {1'b1, av};
        else if (t == st) return {1'b1, sv};
        else              return {r, v};
    endfunction

    // Allocation tag and idle flag seen by decode and fetch.
    always_comb begin
        out_decode_rob_tag = full ? ZERO_TAG_ROB : tail;
        out_fetcher_isidle = !full;
    end

    // Operand query ports for decode.
    always_comb begin
        {out_decode_query_ready1, out_decode_query_value1} = lookup(
            in_decode_query_tag1,
            entry_q[in_decode_query_tag1].ready,
            entry_q[in_decode_query_tag1].value,
            in_alu_cdb_tag, in_alu_cdb_value,
            in_slb_cdb_tag, in_slb_cdb_value);
        {out_decode_query_ready2, out_decode_query_value2} = lookup(
            in_decode_query_tag2,
            entry_q[in_decode_query_tag2].ready,
            entry_q[in_decode_query_tag2].value,
            in_alu_cdb_tag, in_alu_cdb_value,
            in_slb_cdb_tag, in_slb_cdb_value);
    end

    // Entry table update: allocation, CDB capture, flush clears ready bits.
    always_comb begin
        alloc   = in_fetcher_ce && !full && !misbranch_q;
        entry_d = entry_q;
        if (misbranch_q) begin
            for (int i = 0; i < ROB_SIZE; i++) entry_d[i].ready = 1'b0;
        end else begin
            if (alloc) begin
                entry_d[tail] = '{op: in_decode_op, rd: in_decode_rd,
                                  pc: in_decode_pc,
                                  pred: in_decode_pred_taken,
                                  ready: is_store_op(in_decode_op),
                                  value: 32'd0, taken: 1'b0,
                                  target: 32'd0};
            end
            if (in_alu_cdb_tag != ZERO_TAG_ROB) begin
                entry_d[in_alu_cdb_tag].value  = in_alu_cdb_value;
                entry_d[in_alu_cdb_tag].taken  = in_alu_cdb_taken;
                entry_d[in_alu_cdb_tag].target = in_alu_cdb_target;
                entry_d[in_alu_cdb_tag].ready  = 1'b1;
            end
            if (in_slb_cdb_tag != ZERO_TAG_ROB) begin
                entry_d[in_slb_cdb_tag].value = in_slb_cdb_value;
                entry_d[in_slb_cdb_tag].ready = 1'b1;
            end
        end
    end

    // Head commit: one-cycle pulses on the commit outputs, plus redirect.
    always_comb begin
        head_e           = entry_q[head];
        commit           = !empty && head_e.ready && !misbranch_q;
        link             = head_e.pc + 32'd4;
        cvalue           = (is_jal_op(head_e.op) || is_jalr_op(head_e.op))
                           ? link : head_e.value;
        rob_cdb_tag_d    = '0;
        rob_cdb_value_d  = '0;
        reg_rd_d         = '0;
        reg_value_d      = '0;
        reg_tag_d        = '0;
        slb_commit_tag_d = '0;
        misbranch_d      = 1'b0;
        newpc_d          = '0;
        if (commit) begin
            if (is_store_op(head_e.op)) begin
                slb_commit_tag_d = head;
            end else begin
                rob_cdb_tag_d   = head;
                rob_cdb_value_d = cvalue;
                if (head_e.rd != 5'd0) begin
                    reg_rd_d    = head_e.rd;
                    reg_value_d = cvalue;
                    reg_tag_d   = head;
                end
            end
            if (is_jalr_op(head_e.op) ||
                (is_branch_op(head_e.op) && head_e.taken != head_e.pred)) begin
                misbranch_d = 1'b1;
                newpc_d     = (is_jalr_op(head_e.op) || head_e.taken)
                              ? head_e.target : link;
            end
        end
    end

    // State and registered outputs; rdy low holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q          <= '{default: '0};
            rob_cdb_tag_q    <= '0;
            rob_cdb_value_q  <= '0;
            reg_rd_q         <= '0;
            reg_value_q      <= '0;
            reg_tag_q        <= '0;
            slb_commit_tag_q <= '0;
            misbranch_q      <= 1'b0;
            newpc_q          <= '0;
        end else if (rdy) begin
            entry_q          <= entry_d;
            rob_cdb_tag_q    <= rob_cdb_tag_d;
            rob_cdb_value_q  <= rob_cdb_value_d;
            reg_rd_q         <= reg_rd_d;
            reg_value_q      <= reg_value_d;
            reg_tag_q        <= reg_tag_d;
            slb_commit_tag_q <= slb_commit_tag_d;
            misbranch_q      <= misbranch_d;
            newpc_q          <= newpc_d;
        end
    end

    assign out_rob_cdb_tag    = rob_cdb_tag_q;
    assign out_rob_cdb_value  = rob_cdb_value_q;
    assign out_reg_rd         = reg_rd_q;
    assign out_reg_value      = reg_value_q;
    assign out_reg_tag        = reg_tag_q;
    assign out_slb_commit_tag = slb_commit_tag_q;
    assign out_misbranch      = misbranch_q;
    assign out_fetcher_newpc  = newpc_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit with an in-order queue model
// checked every cycle, plus hand-computed literal expectations.
module tb_rob_commit_unit;
    import rob_commit_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, ce;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic [3:0]  qt1, qt2, at, st;
    logic [31:0] av, atgt, sv;
    logic        atk;
    logic [3:0]  o_tag, o_cdb_tag, o_reg_tag, o_slb;
    logic        o_idle, o_r1, o_r2, o_mis;
    logic [31:0] o_v1, o_v2, o_cdb_val, o_reg_val, o_npc;
    logic [4:0]  o_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rob_commit_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_fetcher_ce(ce), .in_decode_op(op), .in_decode_rd(rd),
        .in_decode_pc(pc), .in_decode_pred_taken(pred),
        .out_decode_rob_tag(o_tag), .out_fetcher_isidle(o_idle),
        .in_decode_query_tag1(qt1), .in_decode_query_tag2(qt2),
        .out_decode_query_ready1(o_r1), .out_decode_query_ready2(o_r2),
        .out_decode_query_value1(o_v1), .out_decode_query_value2(o_v2),
        .in_alu_cdb_tag(at), .in_alu_cdb_value(av),
        .in_alu_cdb_taken(atk), .in_alu_cdb_target(atgt),
        .in_slb_cdb_tag(st), .in_slb_cdb_value(sv),
        .out_rob_cdb_tag(o_cdb_tag), .out_rob_cdb_value(o_cdb_val),
        .out_reg_rd(o_rd), .out_reg_value(o_reg_val),
        .out_reg_tag(o_reg_tag), .out_slb_commit_tag(o_slb),
        .out_misbranch(o_mis), .out_fetcher_newpc(o_npc)
    );

    // ---------------- model ----------------
    typedef struct {
        int          tag;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] pc;
        bit          pred;
        bit          ready;
        logic [31:0] value;
        bit          taken;
        logic [31:0] target;
    } ment_t;

    ment_t       mq[$];
    int          ntag;
    logic [3:0]  e_cdb_tag, e_reg_tag, e_slb;
    logic [31:0] e_cdb_val, e_reg_val, e_npc;
    logic [4:0]  e_rd;
    bit          e_mis;

    function automatic bit m_store(logic [5:0] o);
        return o == OP_SB || o == OP_SH || o == OP_SW;
    endfunction

    function automatic bit m_cond(logic [5:0] o);
        return o == OP_BEQ || o == OP_BNE || o == OP_BLT ||
               o == OP_BGE || o == OP_BLTU || o == OP_BGEU;
    endfunction

    task automatic m_clear_outs();
        e_cdb_tag = 0; e_cdb_val = 0; e_rd = 0; e_reg_val = 0;
        e_reg_tag = 0; e_slb = 0; e_mis = 0; e_npc = 0;
    endtask

    task automatic m_reset();
        mq.delete();
        ntag = 1;
        m_clear_outs();
    endtask

    task automatic m_query(input logic [3:0] t, output bit r,
                           output logic [31:0] v);
        r = 0; v = 0;
        if (t == 0) return;
        if (t == at) begin r = 1; v = av; return; end
        if (t == st) begin r = 1; v = sv; return; end
        foreach (mq[i]) if (mq[i].tag == int'(t)) begin
            r = mq[i].ready; v = mq[i].value;
        end
    endtask

    task automatic m_step();
        bit          was_full;
        ment_t       h, e;
        logic [31:0] v;
        if (rst) begin m_reset(); return; end
        if (!rdy) return;
        if (e_mis) begin m_reset(); return; end
        was_full = (mq.size() == 15);
        m_clear_outs();
        if (mq.size() > 0 && mq[0].ready) begin
            h = mq.pop_front();
            v = (h.op == OP_JAL || h.op == OP_JALR) ? h.pc + 4 : h.value;
            if (m_store(h.op)) e_slb = 4'(h.tag);
            else begin
                e_cdb_tag = 4'(h.tag); e_cdb_val = v;
                if (h.rd != 0) begin
                    e_rd = h.rd; e_reg_val = v; e_reg_tag = 4'(h.tag);
                end
            end
            if (h.op == OP_JALR) begin
                e_mis = 1; e_npc = h.target;
            end else if (m_cond(h.op) && h.taken != h.pred) begin
                e_mis = 1; e_npc = h.taken ? h.target : h.pc + 4;
            end
        end
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (at != 0 && e.tag == int'(at)) begin
                e.ready = 1; e.value = av; e.taken = atk; e.target = atgt;
            end
            if (st != 0 && e.tag == int'(st)) begin
                e.ready = 1; e.value = sv;
            end
            mq[i] = e;
        end
        if (ce && !was_full) begin
            e = '{tag: ntag, op: op, rd: rd, pc: pc, pred: pred,
                  ready: m_store(op), value: 0, taken: 0, target: 0};
            mq.push_back(e);
            ntag = (ntag == 15) ? 1 : ntag + 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic check_all();
        bit          r1, r2;
        logic [31:0] v1, v2;
        m_query(qt1, r1, v1);
        m_query(qt2, r2, v2);
        chk("rob_tag", 32'(o_tag), (mq.size() == 15) ? 0 : ntag);
        chk("isidle", 32'(o_idle), 32'(mq.size() != 15));
        chk("q_ready1", 32'(o_r1), 32'(r1));
        chk("q_value1", o_v1, v1);
        chk("q_ready2", 32'(o_r2), 32'(r2));
        chk("q_value2", o_v2, v2);
        chk("cdb_tag", 32'(o_cdb_tag), 32'(e_cdb_tag));
        chk("cdb_value", o_cdb_val, e_cdb_val);
        chk("reg_rd", 32'(o_rd), 32'(e_rd));
        chk("reg_value", o_reg_val, e_reg_val);
        chk("reg_tag", 32'(o_reg_tag), 32'(e_reg_tag));
        chk("slb_commit", 32'(o_slb), 32'(e_slb));
        chk("misbranch", 32'(o_mis), 32'(e_mis));
        chk("newpc", o_npc, e_npc);
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        m_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clr();
        ce = 0; op = OP_NOP; rd = 0; pc = 0; pred = 0;
        qt1 = 0; qt2 = 0; at = 0; av = 0; atk = 0; atgt = 0;
        st = 0; sv = 0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1; rdy = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_reset();
        rst = 0;
    endtask

    task automatic alloc(input logic [5:0] o, input logic [4:0] r,
                         input logic [31:0] p, input logic pr);
        clr();
        ce = 1; op = o; rd = r; pc = p; pred = pr;
        cyc();
    endtask

    task automatic alu(input logic [3:0] t, input logic [31:0] v,
                       input logic tk, input logic [31:0] tg);
        clr();
        at = t; av = v; atk = tk; atgt = tg;
        cyc();
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        bit seen;

        // Reset state.
        do_reset();
        chk("rst_tag", 32'(o_tag), 1);
        chk("rst_idle", 32'(o_idle), 1);
        chk("rst_cdb", 32'(o_cdb_tag), 0);
        chk("rst_mis", 32'(o_mis), 0);

        // Out-of-order completion, in-order commit.
        alloc(OP_ADD, 5'd1, 32'h0, 0);
        alloc(OP_ADD, 5'd2, 32'h4, 0);
        alloc(OP_ADD, 5'd3, 32'h8, 0);
        alu(4'd2, 32'h22, 0, 0);
        alu(4'd1, 32'h11, 0, 0);
        idle(1);
        chk("c1_tag", 32'(o_cdb_tag), 1);
        chk("c1_val", o_cdb_val, 32'h11);
        chk("c1_rd", 32'(o_rd), 1);
        idle(1);
        chk("c2_tag", 32'(o_cdb_tag), 2);
        chk("c2_val", o_cdb_val, 32'h22);
        chk("c2_rd", 32'(o_rd), 2);
        idle(1);
        chk("c3_none", 32'(o_cdb_tag), 0);
        alu(4'd3, 32'h33, 0, 0);
        idle(2);

        // Fill, refuse while full (even with a commit), wrap to tag 1.
        do_reset();
        for (int i = 1; i <= 15; i++) alloc(OP_ADD, 5'(i), 32'(4 * i), 0);
        chk("full_idle", 32'(o_idle), 0);
        chk("full_tag", 32'(o_tag), 0);
        alloc(OP_ADD, 5'd9, 32'h900, 0);
        alu(4'd1, 32'h1, 0, 0);
        alloc(OP_ADD, 5'd9, 32'hF00, 0);
        chk("free_tag", 32'(o_tag), 1);
        chk("free_idle", 32'(o_idle), 1);
        alloc(OP_ADD, 5'd4, 32'h40, 0);
        chk("refull_tag", 32'(o_tag), 0);
        idle(1);

        // Mispredicted conditional branch; wrong-path work discarded.
        do_reset();
        alloc(OP_BEQ, 5'd0, 32'h100, 0);
        alloc(OP_ADD, 5'd5, 32'h104, 0);
        alu(4'd2, 32'h7, 0, 0);
        alu(4'd1, 32'h0, 1, 32'h200);
        idle(1);
        chk("br_mis", 32'(o_mis), 1);
        chk("br_npc", o_npc, 32'h200);
        chk("br_cdb", 32'(o_cdb_tag), 1);
        alloc(OP_ADD, 5'd6, 32'h300, 0);
        chk("br_mis_off", 32'(o_mis), 0);
        chk("br_cdb_off", 32'(o_cdb_tag), 0);
        chk("br_tag1", 32'(o_tag), 1);
        idle(1);

        // jalr: link value, always redirects to target.
        alloc(OP_JALR, 5'd1, 32'h40, 0);
        alu(4'd1, 32'h0, 1, 32'h80);
        idle(1);
        chk("jalr_link", o_reg_val, 32'h44);
        chk("jalr_mis", 32'(o_mis), 1);
        chk("jalr_npc", o_npc, 32'h80);
        idle(2);

        // Correctly predicted branch and not-taken mispredict.
        alloc(OP_BNE, 5'd0, 32'h10, 1);
        alloc(OP_BLT, 5'd0, 32'h14, 1);
        alu(4'd1, 32'h0, 1, 32'h30);
        alu(4'd2, 32'h0, 0, 32'h50);
        chk("bp_ok", 32'(o_mis), 0);
        idle(1);
        chk("bnt_mis", 32'(o_mis), 1);
        chk("bnt_npc", o_npc, 32'h18);
        idle(2);

        // Query forwarding, load capture, store commit.
        do_reset();
        alloc(OP_ADD, 5'd1, 32'h0, 0);
        alloc(OP_ADD, 5'd2, 32'h4, 0);
        alloc(OP_LW, 5'd3, 32'h8, 0);
        alloc(OP_ADD, 5'd4, 32'hC, 0);
        clr();
        qt1 = 4'd4; at = 4'd4; av = 32'hABCD;
        qt2 = 4'd3; st = 4'd3; sv = 32'h55;
        #1;
        chk("fwd_r1", 32'(o_r1), 1);
        chk("fwd_v1", o_v1, 32'hABCD);
        chk("fwd_r2", 32'(o_r2), 1);
        chk("fwd_v2", o_v2, 32'h55);
        cyc();
        clr();
        qt1 = 4'd4; qt2 = 4'd1;
        cyc();
        alu(4'd1, 32'h10, 0, 0);
        alu(4'd2, 32'h20, 0, 0);
        alloc(OP_SW, 5'd0, 32'h20, 0);
        clr();
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cyc();
            if (o_slb != 0) seen = 1;
        end
        chk("st_seen", 32'(seen), 1);
        chk("st_tag", 32'(o_slb), 5);
        chk("st_cdb", 32'(o_cdb_tag), 0);
        chk("st_rd", 32'(o_rd), 0);
        idle(1);
        chk("st_pulse", 32'(o_slb), 0);

        // rdy low freezes commit and holds pulses.
        do_reset();
        alloc(OP_ADD, 5'd7, 32'h0, 0);
        alu(4'd1, 32'h77, 0, 0);
        clr();
        rdy = 0;
        for (int i = 0; i < 3; i++) cyc();
        chk("rdy_hold", 32'(o_cdb_tag), 0);
        rdy = 1;
        cyc();
        chk("rdy_cdb", 32'(o_cdb_tag), 1);
        chk("rdy_rd", 32'(o_rd), 7);
        chk("rdy_val", o_reg_val, 32'h77);
        rdy = 0;
        for (int i = 0; i < 2; i++) cyc();
        chk("rdy_freeze", 32'(o_cdb_tag), 1);
        rdy = 1;
        cyc();
        chk("rdy_pulse", 32'(o_cdb_tag), 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer for the Tomasulo core.
- Allocates the ROB tags that the decoder hands to the ALU reservation station and the SLB, and collects results from the ALU and SLB CDBs.
- Commits in program order and drives the commit-side CDB (`out_rob_cdb_*`) that the reservation stations consume.
- Detects branch mispredictions at commit and raises the global `misbranch` flush.

Parameters:
- ROB_SIZE, 16, number of tag slots; slot 0 is reserved as `ZERO_TAG_ROB`, so ROB_SIZE-1 entries are usable.
- TAG_W, 4, tag width; must equal the width of `ROB_TAG_WIDTH`.

Ports:
- clk  in  1  clock; one clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global enable; when low, all state and outputs hold.
- in_fetcher_ce  in  1  allocate one entry this cycle.
- in_decode_op  in  INSIDE_OPCODE_WIDTH  op of the allocated instruction.
- in_decode_rd  in  5  destination register; 0 means no write.
- in_decode_pc  in  32  pc of the allocated instruction.
- in_decode_pred_taken  in  1  fetcher's prediction for this branch.
- out_decode_rob_tag  out  TAG_W  combinational; tag that will be allocated; `ZERO_TAG_ROB` when full.
- out_fetcher_isidle  out  1  combinational; high when not full.
- in_decode_query_tag1/2  in  TAG_W  operand tags looked up by decode.
- out_decode_query_ready1/2  out  1  combinational; entry has its result.
- out_decode_query_value1/2  out  32  combinational; stored result for the queried tag.
- in_alu_cdb_tag  in  TAG_W  ALU result tag; 0 means idle.
- in_alu_cdb_value  in  32  ALU result value.
- in_alu_cdb_taken  in  1  actual branch outcome.
- in_alu_cdb_target  in  32  actual next pc for branch/jalr.
- in_slb_cdb_tag  in  TAG_W  load result tag; accepted regardless of the SLB's ioin flag.
- in_slb_cdb_value  in  32  load result value.
- out_rob_cdb_tag  out  TAG_W  committed tag; 0 means none.
- out_rob_cdb_value  out  32  committed value.
- out_reg_rd  out  5  register file write index; 0 means none.
- out_reg_value  out  32  register file write value.
- out_reg_tag  out  TAG_W  register file clears its rename only if its current rename equals this tag.
- out_slb_commit_tag  out  TAG_W  store at ROB head is licensed to write memory.
- out_misbranch  out  1  one-cycle flush pulse.
- out_fetcher_newpc  out  32  redirect pc, valid with `out_misbranch`.

Behaviour:
- Reset: head=tail=1, count=0, all entries not-ready. All registered outputs are 0: `out_rob_cdb_tag`, `out_reg_rd`, `out_reg_tag`, `out_slb_commit_tag`, `out_misbranch`, `out_fetcher_newpc`, and the value outputs.
- Pointers: head and tail cycle 1..ROB_SIZE-1. Wrap is from ROB_SIZE-1 to 1; tag 0 is never issued.
- Full when count == ROB_SIZE-1.
- Allocate: when `in_fetcher_ce` is high and not full at the start of the cycle, write op/rd/pc/pred into `entry[tail]`, clear ready, tail++, count++.
  - `in_fetcher_ce` while full is ignored.
  - Store ops are marked ready at allocation.
- Result capture: a nonzero ALU tag sets value/ready (plus taken/target) in that entry. A nonzero SLB tag sets value/ready. Both may land on different entries in the same cycle.
- Query path: `out_decode_query_ready` is the entry's ready bit, with a forwarding bypass. If the queried tag equals this cycle's ALU or SLB CDB tag, report ready with the CDB value. A queried tag of 0 returns ready=0.
- Commit: at most one per cycle, when count>0 and `entry[head]` is ready. Registered outputs update on the next edge:
  - non-store: `out_rob_cdb_tag/value` = head tag/value.
  - rd!=0: `out_reg_rd/value/tag` driven.
  - store: `out_slb_commit_tag` = head tag.
  - then head++, count--.
- Every commit output not driven in a cycle returns to 0 (one-cycle pulses).
- Branch ops: committed value is the link (pc+4) for jal/jalr.
  - Misprediction: conditional branch with taken != pred, or jalr (always).
  - On mispredict, commit the head normally, then the next edge asserts `out_misbranch`=1 with `out_fetcher_newpc` = taken ? target : pc+4 (jalr: target).
- Flush: the cycle `out_misbranch` is high, head=tail=1, count=0, all ready bits cleared. Allocation and CDB capture in that cycle are discarded.
- Simultaneous alloc and commit: count unchanged. A full buffer with a commit this cycle still refuses allocation; the slot frees next cycle.
- `rst` mid-operation overrides all pending commits and flush.
- `rdy` low freezes everything, including pulse outputs.

Decomposition:
- constant.v gains `ROB_SIZE`, `ROB_TAG_WIDTH`, `ZERO_TAG_ROB`, and op-class ranges `IS_BRANCH_OP`, `IS_JALR_OP`, `IS_STORE_OP` as macros over `INSIDE_OPCODE_WIDTH`.
- One natural sub-module: rob_ptr_ring, which handles the head/tail/count wrap 1..N-1 and the full/empty signals.

Test Plan:
- Reset, then allocate 3 ALU ops at pc 0x0,0x4,0x8 (tags 1,2,3). ALU returns tag 2 = 0x22, then tag 1 = 0x11 → commit tag 1 on the cycle after tag 1 returns, tag 2 on the following cycle, in order; `out_reg_rd` matches.
- Allocate 15 entries → `out_fetcher_isidle`=0, `out_decode_rob_tag`=0. 16th ce ignored. One commit frees a slot; next alloc gets tag 1 (wrap).
- Branch at pc 0x100, pred_taken=0; ALU tag returns taken=1, target 0x200 → one-cycle `out_misbranch`=1, `out_fetcher_newpc`=0x200. Next cycle `out_decode_rob_tag`=1 and count=0.
- Query tag 4 while ALU CDB broadcasts tag 4 = 0xABCD → `out_decode_query_ready1`=1, value 0xABCD, same cycle.
- Store at head (tag 5) → `out_slb_commit_tag`=5 for one cycle, `out_rob_cdb_tag`=0, `out_reg_rd`=0.
- Hold `rdy`=0 for 3 cycles with a ready head → no commit. Commit occurs on the first edge after `rdy` returns high.
